// File: rtl/nes_multi_controller.sv
// Polls 1..NUM_PADS NES/SNES pads over a shared latch/clock and captures their serial data.
// Define NES_MULTI_EDGE_EN to enable the o_pressed newly-pressed flags (tied to 0 otherwise).
module nes_multi_controller #(
    parameter int CYCLES_PER_PULSE = 150,
    parameter int NUM_PADS         = 2,
    parameter int BITS_PER_PAD     = 8,
    parameter int AUTO_POLL_CYCLES = 0
) (
    input  logic                             clk,
    input  logic                             i_rst_n,
    input  logic                             i_read_buttons,
    output logic                             o_busy,
    output logic                             o_valid,
    output logic [NUM_PADS*BITS_PER_PAD-1:0] o_buttons,
    output logic [NUM_PADS*BITS_PER_PAD-1:0] o_pressed,
    input  logic [NUM_PADS-1:0]              i_controller_data,
    output logic                             o_controller_latch,
    output logic                             o_controller_clock
);
    localparam int P     = CYCLES_PER_PULSE;
    localparam int W     = NUM_PADS * BITS_PER_PAD;
    localparam int PH_W  = $clog2(2 * P);
    localparam int BIT_W = $clog2(BITS_PER_PAD);

    localparam logic [PH_W-1:0]  PH_LAST       = PH_W'(2 * P - 1);
    localparam logic [PH_W-1:0]  PH_HALF       = PH_W'(P);
    localparam logic [PH_W-1:0]  PH_LATCH_LAST = PH_W'(P - 1);
    localparam logic [PH_W-1:0]  PH_SAMPLE     = PH_W'(P + P / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST      = BIT_W'(BITS_PER_PAD - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, LATCH = 2'd1, SHIFT = 2'd2, DONE = 2'd3} state_t;

    state_t           state_q, state_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [W-1:0]     shadow_q, shadow_d;
    logic [W-1:0]     buttons_q, buttons_d;
    logic             auto_tick;
    logic             start;
    logic             sample;
    logic             finish;

    // phase_q is the offset inside the current 2P-cycle bit slot; slot 0 spans the latch pulse
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        start   = 1'b0;
        sample  = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_read_buttons || auto_tick) begin
                    state_d = LATCH;
                    phase_d = '0;
                    bit_d   = '0;
                    start   = 1'b1;
                end
            end
            LATCH: begin
                phase_d = phase_q + PH_W'(1);
                if (phase_q == PH_LATCH_LAST) state_d = SHIFT;
            end
            SHIFT: begin
                sample = (phase_q == PH_SAMPLE);
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    if (bit_q == BIT_LAST) begin
                        finish  = 1'b1;
                        state_d = DONE;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // First serial bit ends up at the MSB of each pad field; pad data is active-low
    always_comb begin
        shadow_d = shadow_q;
        if (start) begin
            shadow_d = '0;
        end else if (sample) begin
            for (int p = 0; p < NUM_PADS; p++) begin
                shadow_d[p*BITS_PER_PAD +: BITS_PER_PAD] =
                    {shadow_q[p*BITS_PER_PAD +: BITS_PER_PAD-1], ~i_controller_data[p]};
            end
        end
    end

    always_comb begin
        buttons_d = buttons_q;
        if (finish) buttons_d = shadow_q;
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            bit_q     <= '0;
            shadow_q  <= '0;
            buttons_q <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            shadow_q  <= shadow_d;
            buttons_q <= buttons_d;
        end
    end

    generate
        if (AUTO_POLL_CYCLES > 0) begin : g_auto
            localparam int AW = $clog2(AUTO_POLL_CYCLES);
            localparam logic [AW-1:0] POLL_LAST = AW'(AUTO_POLL_CYCLES - 1);
            logic [AW-1:0] poll_cnt_q, poll_cnt_d;
            logic          tick_q, tick_d;

            // registered tick lands exactly AUTO_POLL_CYCLES cycles after reset release
            always_comb begin
                tick_d     = (poll_cnt_q == POLL_LAST);
                poll_cnt_d = tick_d ? '0 : poll_cnt_q + AW'(1);
            end

            always_ff @(posedge clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    poll_cnt_q <= '0;
                    tick_q     <= 1'b0;
                end else begin
                    poll_cnt_q <= poll_cnt_d;
                    tick_q     <= tick_d;
                end
            end
            assign auto_tick = tick_q;
        end else begin : g_no_auto
            assign auto_tick = 1'b0;
        end
    endgenerate

`ifdef NES_MULTI_EDGE_EN
    logic [W-1:0] pressed_q, pressed_d;

    always_comb begin
        pressed_d = pressed_q;
        if (finish) pressed_d = shadow_q & ~buttons_q;
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) pressed_q <= '0;
        else          pressed_q <= pressed_d;
    end
    assign o_pressed = pressed_q;
`else
    assign o_pressed = '0;
`endif

    assign o_controller_latch = (state_q == LATCH);
    assign o_controller_clock = !((state_q == SHIFT) && (bit_q != '0) && (phase_q < PH_HALF));
    assign o_busy             = (state_q != IDLE);
    assign o_valid            = (state_q == DONE);
    assign o_buttons          = buttons_q;

endmodule
